// File: rtl/ds1302_time_poller.sv
// rtl/ds1302_time_poller.sv - periodic DS1302 time/date register poller
//
// Purpose:
//   Every POLL_PERIOD clocks (while enabled) reads the seven DS1302 time
//   registers through an external serial driver, one read command at a
//   time, collects them in shadow registers and publishes a consistent BCD
//   snapshot only when all seven bytes have arrived. Each handshake phase
//   is bounded by TIMEOUT clocks; an aborted cycle leaves the snapshot as is.
//
// Ports:
//   clk                 system clock, rising edge
//   reset_n             asynchronous active-low reset
//   i_enable            allow new poll cycles to start
//   i_busy              driver busy (asynchronous, synchronized here)
//   i_receive[7:0]      byte returned by the driver, valid after busy falls
//   o_addr[7:0]         read command address for the driver
//   o_valid             request strobe to the driver
//   o_sec..o_year[7:0]  published BCD snapshot (o_sec has CH stripped)
//   o_halt              clock-halt flag from the seconds register
//   o_update            one-cycle pulse, new snapshot published
//   o_timeout           one-cycle pulse, poll cycle aborted
module ds1302_time_poller #(
   parameter int POLL_PERIOD = 10_000_000,
   parameter int TIMEOUT     = 100_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_enable,
   input  logic       i_busy,
   input  logic [7:0] i_receive,
   output logic [7:0] o_addr,
   output logic       o_valid,
   output logic [7:0] o_sec,
   output logic [7:0] o_min,
   output logic [7:0] o_hour,
   output logic [7:0] o_date,
   output logic [7:0] o_month,
   output logic [7:0] o_day,
   output logic [7:0] o_year,
   output logic       o_halt,
   output logic       o_update,
   output logic       o_timeout
);

   localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_DONE,
      ST_CAPTURE,
      ST_PUBLISH
   } state_t;

   state_t          state_q;
   logic [2:0]      idx_q;
   logic [PW-1:0]   per_cnt_q;
   logic [PW-1:0]   per_cnt_d;
   logic [TW-1:0]   phase_q;
   logic            busy_meta_q;
   logic            busy_sync_q;
   logic            busy_prev_q;
   logic [7:0]      shadow_q [7];
   logic [7:0]      shadow_d [7];

   logic [7:0]      addr_q;
   logic            valid_q;
   logic [7:0]      sec_q;
   logic [7:0]      min_q;
   logic [7:0]      hour_q;
   logic [7:0]      date_q;
   logic [7:0]      month_q;
   logic [7:0]      day_q;
   logic [7:0]      year_q;
   logic            halt_q;
   logic            update_q;
   logic            timeout_q;

   logic            per_wrap;
   logic            busy_rise;
   logic            busy_fall;
   logic            phase_expired;
   logic [2:0]      idx_inc;

   assign per_wrap      = (per_cnt_q == PW'(POLL_PERIOD - 1));
   assign busy_rise     = busy_sync_q & ~busy_prev_q;
   assign busy_fall     = ~busy_sync_q & busy_prev_q;
   assign phase_expired = (phase_q == TW'(TIMEOUT - 1));
   assign idx_inc       = idx_q + 3'd1;

   always_comb begin
      per_cnt_d = per_wrap ? '0 : per_cnt_q + 1'b1;
   end

   // Shadow byte being captured this cycle is also forwarded so the final
   // byte can be published on the same edge it is stored.
   always_comb begin
      for (int i = 0; i < 7; i++) begin
         shadow_d[i] = shadow_q[i];
         if (state_q == ST_CAPTURE && idx_q == 3'(i)) begin
            shadow_d[i] = i_receive;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         per_cnt_q   <= '0;
         busy_meta_q <= 1'b0;
         busy_sync_q <= 1'b0;
         busy_prev_q <= 1'b0;
         for (int i = 0; i < 7; i++) begin
            shadow_q[i] <= 8'h00;
         end
      end else begin
         per_cnt_q   <= per_cnt_d;
         busy_meta_q <= i_busy;
         busy_sync_q <= busy_meta_q;
         busy_prev_q <= busy_sync_q;
         for (int i = 0; i < 7; i++) begin
            shadow_q[i] <= shadow_d[i];
         end
      end
   end

   // Published outputs are loaded on the CAPTURE->PUBLISH edge so that the
   // new snapshot and o_update are both visible during the PUBLISH cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= 3'd0;
         phase_q   <= '0;
         addr_q    <= 8'h00;
         valid_q   <= 1'b0;
         sec_q     <= 8'h00;
         min_q     <= 8'h00;
         hour_q    <= 8'h00;
         date_q    <= 8'h00;
         month_q   <= 8'h00;
         day_q     <= 8'h00;
         year_q    <= 8'h00;
         halt_q    <= 1'b0;
         update_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         update_q  <= 1'b0;
         timeout_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // Wraps seen outside IDLE are simply lost.
               if (per_wrap && i_enable) begin
                  state_q <= ST_REQ;
                  idx_q   <= 3'd0;
                  phase_q <= '0;
                  addr_q  <= 8'h81;
                  valid_q <= 1'b1;
               end
            end
            ST_REQ: begin
               if (busy_rise) begin
                  state_q <= ST_WAIT_DONE;
                  valid_q <= 1'b0;
                  phase_q <= '0;
               end else if (phase_expired) begin
                  state_q   <= ST_IDLE;
                  valid_q   <= 1'b0;
                  timeout_q <= 1'b1;
               end else begin
                  phase_q <= phase_q + 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               if (busy_fall) begin
                  state_q <= ST_CAPTURE;
               end else if (phase_expired) begin
                  state_q   <= ST_IDLE;
                  timeout_q <= 1'b1;
               end else begin
                  phase_q <= phase_q + 1'b1;
               end
            end
            ST_CAPTURE: begin
               if (idx_q == 3'd6) begin
                  state_q  <= ST_PUBLISH;
                  update_q <= 1'b1;
                  sec_q    <= {1'b0, shadow_d[0][6:0]};
                  halt_q   <= shadow_d[0][7];
                  min_q    <= shadow_d[1];
                  hour_q   <= shadow_d[2];
                  date_q   <= shadow_d[3];
                  month_q  <= shadow_d[4];
                  day_q    <= shadow_d[5];
                  year_q   <= shadow_d[6];
               end else begin
                  state_q <= ST_REQ;
                  idx_q   <= idx_inc;
                  phase_q <= '0;
                  addr_q  <= 8'h81 + {4'b0000, idx_inc, 1'b0};
                  valid_q <= 1'b1;
               end
            end
            ST_PUBLISH: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_addr    = addr_q;
   assign o_valid   = valid_q;
   assign o_sec     = sec_q;
   assign o_min     = min_q;
   assign o_hour    = hour_q;
   assign o_date    = date_q;
   assign o_month   = month_q;
   assign o_day     = day_q;
   assign o_year    = year_q;
   assign o_halt    = halt_q;
   assign o_update  = update_q;
   assign o_timeout = timeout_q;

endmodule
